// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with sequential advance, absolute
// jump, PC-relative branch, and call/return through an internal return-address
// stack (RAS) with sticky overflow/underflow flags.
//
// Ports:
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   halt            freezes pc, RAS, count and flags (clear_flags ignored too)
//   clear_flags     synchronous clear of the sticky flags (a same-edge set wins)
//   pc_op[2:0]      0 SEQ, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5-7 treated as SEQ
//   target          absolute destination for JUMP and CALL
//   offset          two's-complement displacement for BRANCH
//   pc              registered fetch address
//   stack_count     number of valid RAS entries (0..STACK_DEPTH)
//   stack_overflow  sticky: CALL issued with the RAS full
//   stack_underflow sticky: RET issued with the RAS empty
module pc_sequencer #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned            INCREMENT    = 1,
  parameter int unsigned            STACK_DEPTH  = 8
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            halt,
  input  logic                            clear_flags,
  input  logic [2:0]                      pc_op,
  input  logic [ADDR_WIDTH-1:0]           target,
  input  logic [ADDR_WIDTH-1:0]           offset,
  output logic [ADDR_WIDTH-1:0]           pc,
  output logic [$clog2(STACK_DEPTH):0]    stack_count,
  output logic                            stack_overflow,
  output logic                            stack_underflow
);

  localparam int unsigned PTR_W = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_BRANCH = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;

  // Storage is not reset; only stack_count says which entries are valid.
  logic [ADDR_WIDTH-1:0] ras [STACK_DEPTH];

  logic [ADDR_WIDTH-1:0] seq, pc_next;
  logic [CNT_W-1:0]      cnt_m1;
  logic [PTR_W-1:0]      top_idx, push_idx;
  logic                  full, empty, is_call, is_ret, push, pop;

  always_comb begin
    seq      = pc + ADDR_WIDTH'(INCREMENT);
    full     = (stack_count == CNT_W'(STACK_DEPTH));
    empty    = (stack_count == '0);
    cnt_m1   = stack_count - 1'b1;
    top_idx  = cnt_m1[PTR_W-1:0];
    push_idx = stack_count[PTR_W-1:0];
    is_call  = !halt && (pc_op == OP_CALL);
    is_ret   = !halt && (pc_op == OP_RET);
    push     = is_call && !full;
    pop      = is_ret && !empty;

    pc_next = seq;
    case (pc_op)
      OP_JUMP:   pc_next = target;
      OP_BRANCH: pc_next = pc + offset;
      OP_CALL:   pc_next = target;
      // RET on an empty stack falls through to seq
      OP_RET:    pc_next = empty ? seq : ras[top_idx];
      default:   pc_next = seq;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc              <= RESET_VECTOR;
      stack_count     <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!halt) begin
      pc <= pc_next;
      if (push)     stack_count <= stack_count + 1'b1;
      else if (pop) stack_count <= cnt_m1;
      // clear first, then OR in a new event so a same-edge set wins
      stack_overflow  <= (stack_overflow  && !clear_flags) || (is_call && full);
      stack_underflow <= (stack_underflow && !clear_flags) || (is_ret && empty);
    end
  end

  always_ff @(posedge clock) begin
    if (push) ras[push_idx] <= seq;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// ops, all compared against a queue-based behavioural model.
module tb_pc_sequencer;

  localparam int          AW    = 32;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RV    = 32'h100;

  logic          clock, reset_n, halt, clear_flags;
  logic [2:0]    pc_op;
  logic [AW-1:0] target, offset, pc;
  logic [3:0]    stack_count;
  logic          stack_overflow, stack_underflow;

  pc_sequencer #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV), .INCREMENT(1), .STACK_DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .halt(halt), .clear_flags(clear_flags),
    .pc_op(pc_op), .target(target), .offset(offset), .pc(pc),
    .stack_count(stack_count), .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // behavioural model
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf, m_udf;

  task automatic model_reset();
    m_pc = RV; m_ras.delete(); m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic model_step(input logic [2:0] op, input logic [31:0] t,
                            input logic [31:0] o, input logic h, input logic c);
    logic [31:0] s;
    logic ovf_set, udf_set;
    if (h) return;
    s = m_pc + 32'd1;
    ovf_set = 1'b0; udf_set = 1'b0;
    case (op)
      3'd1: m_pc = t;
      3'd2: m_pc = m_pc + o;
      3'd3: begin
        if (m_ras.size() < DEPTH) m_ras.push_back(s); else ovf_set = 1'b1;
        m_pc = t;
      end
      3'd4: begin
        if (m_ras.size() == 0) begin m_pc = s; udf_set = 1'b1; end
        else m_pc = m_ras.pop_back();
      end
      default: m_pc = s;
    endcase
    if (c) begin m_ovf = 1'b0; m_udf = 1'b0; end
    m_ovf = m_ovf | ovf_set;
    m_udf = m_udf | udf_set;
  endtask

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    expect_eq({tag, ".pc"},  pc, m_pc);
    expect_eq({tag, ".cnt"}, {28'd0, stack_count}, m_ras.size());
    expect_eq({tag, ".ovf"}, {31'd0, stack_overflow}, {31'd0, m_ovf});
    expect_eq({tag, ".udf"}, {31'd0, stack_underflow}, {31'd0, m_udf});
  endtask

  // Call just after a rising edge (or at a negedge): drive, take one edge, check.
  task automatic apply(input string tag, input logic [2:0] op, input logic [31:0] t,
                       input logic [31:0] o, input logic h, input logic c);
    pc_op = op; target = t; offset = o; halt = h; clear_flags = c;
    @(posedge clock);
    model_step(op, t, o, h, c);
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #3 reset_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    expect_eq({tag, ".rv"}, pc, RV);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1; halt = 1'b0; clear_flags = 1'b0;
    pc_op = 3'd0; target = '0; offset = '0;
    model_reset();

    // reset asserted mid-cycle, then three SEQs
    @(posedge clock); #2;
    async_reset("reset");
    apply("seq1", 3'd0, 0, 0, 0, 0); expect_eq("seq1.abs", pc, 32'h101);
    apply("seq2", 3'd0, 0, 0, 0, 0); expect_eq("seq2.abs", pc, 32'h102);
    apply("seq3", 3'd0, 0, 0, 0, 0); expect_eq("seq3.abs", pc, 32'h103);

    // jump, negative branch, wrap
    apply("jmp10", 3'd1, 32'h10, 0, 0, 0);
    apply("brneg", 3'd2, 0, 32'hFFFF_FFFC, 0, 0); expect_eq("brneg.abs", pc, 32'h0C);
    apply("jmpmax", 3'd1, 32'hFFFF_FFFF, 0, 0, 0);
    apply("wrap", 3'd0, 0, 0, 0, 0); expect_eq("wrap.abs", pc, 32'h0);

    // nested call/return
    apply("jmp20", 3'd1, 32'h20, 0, 0, 0);
    apply("call80", 3'd3, 32'h80, 0, 0, 0); expect_eq("call80.abs", pc, 32'h80);
    apply("callC0", 3'd3, 32'hC0, 0, 0, 0); expect_eq("callC0.cnt", {28'd0, stack_count}, 2);
    apply("ret1", 3'd4, 0, 0, 0, 0); expect_eq("ret1.abs", pc, 32'h81);
    apply("ret2", 3'd4, 0, 0, 0, 0); expect_eq("ret2.abs", pc, 32'h21);

    // overflow: 9 calls then 8 returns
    for (int i = 0; i < 9; i++)
      apply("ovcall", 3'd3, 32'h1000 + 32'(i) * 32'h10, 0, 0, 0);
    expect_eq("ov9.pc", pc, 32'h1080);
    expect_eq("ov9.flag", {31'd0, stack_overflow}, 1);
    expect_eq("ov9.cnt", {28'd0, stack_count}, 8);
    for (int i = 0; i < 8; i++) apply("ovret", 3'd4, 0, 0, 0, 0);
    expect_eq("ovret.last", pc, 32'h22);
    apply("ovclr", 3'd0, 0, 0, 0, 1);

    // underflow and flag clear
    apply("jmp40", 3'd1, 32'h40, 0, 0, 0);
    apply("udf", 3'd4, 0, 0, 0, 0); expect_eq("udf.abs", pc, 32'h41);
    apply("clrhalt", 3'd0, 0, 0, 1, 1); expect_eq("clrhalt.flag", {31'd0, stack_underflow}, 1);
    apply("clr", 3'd0, 0, 0, 0, 1); expect_eq("clr.flag", {31'd0, stack_underflow}, 0);
    apply("udfclr", 3'd4, 0, 0, 0, 1); expect_eq("udfclr.flag", {31'd0, stack_underflow}, 1);

    // halt with CALL pending, then release
    apply("prep", 3'd3, 32'h300, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply("halt", 3'd3, 32'h500, 0, 1, 0);
    apply("unhalt", 3'd3, 32'h500, 0, 0, 0); expect_eq("unhalt.abs", pc, 32'h500);

    // reset in the middle of operation
    async_reset("midrst");
    apply("postrst", 3'd0, 0, 0, 0, 0);

    // random ops, call/ret weighted to exercise both stack limits
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      int r;
      r = $urandom_range(0, 99);
      if (r < 30)      op = 3'd3;
      else if (r < 55) op = 3'd4;
      else             op = 3'($urandom_range(0, 7));
      apply("rand", op, $urandom, $urandom,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
